// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the vblank DMA engine: register word offsets, CTRL
// write/read bit positions, the engine state encoding and the helper that
// picks the first state after a GO (or after the awaited vblank edge).
// ---------------------------------------------------------------------------
package dma_pkg;

  // Register word offsets relative to BASE_ADDR
  localparam logic [1:0] OFF_SRC  = 2'd0;
  localparam logic [1:0] OFF_DST  = 2'd1;
  localparam logic [1:0] OFF_LEN  = 2'd2;
  localparam logic [1:0] OFF_CTRL = 2'd3;

  // CTRL write bits
  localparam int CTRL_GO    = 0;
  localparam int CTRL_VBL   = 1;
  localparam int CTRL_ABORT = 2;

  // CTRL read (status) bits
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ARMED = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } dma_state_e;

  function automatic logic is_busy(input dma_state_e s);
    return (s == ST_READ) || (s == ST_WAIT) || (s == ST_WRITE);
  endfunction

  // A zero-length copy goes straight to DONE so it never touches the bus.
  function automatic dma_state_e start_state(input logic wait_vbl,
                                             input logic [15:0] len);
    if (wait_vbl)
      return ST_ARMED;
    else if (len == 16'd0)
      return ST_DONE;
    else
      return ST_READ;
  endfunction

endpackage

// File: rtl/vblank_dma_if.sv
// ---------------------------------------------------------------------------
// vblank_dma_if
// CPU16 register-port and DMA bus-port signals of the vblank DMA engine.
//   cpu_addr/cpu_wdata/cpu_we : CPU register access into the engine
//   reg_hit/reg_rdata         : combinational decode and readback
//   dma_grant                 : bus free of renderer reads this cycle
//   dma_addr/dma_rdata        : source read address and returned data
//   dma_wdata/dma_we          : RAM write data and strobe
// slave  = the DMA engine view, master = the platform / bus side.
// ---------------------------------------------------------------------------
interface vblank_dma_if;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic        reg_hit;
  logic [15:0] reg_rdata;
  logic        dma_grant;
  logic [15:0] dma_addr;
  logic [15:0] dma_rdata;
  logic [15:0] dma_wdata;
  logic        dma_we;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, dma_grant, dma_rdata,
    output reg_hit, reg_rdata, dma_addr, dma_wdata, dma_we
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, dma_grant, dma_rdata,
    input  reg_hit, reg_rdata, dma_addr, dma_wdata, dma_we
  );
endinterface

// File: rtl/vblank_dma_regs.sv
// ---------------------------------------------------------------------------
// vblank_dma_regs
// Register file of the DMA engine: address decode, SRC/DST/LEN working
// registers, sticky done bit, CTRL strobes and readback mux.
//   clk, reset             : clock, async active-low reset
//   cpu_addr/wdata/we      : CPU register access
//   reg_hit, reg_rdata     : combinational decode / readback
//   lock                   : engine busy or armed; blocks SRC/DST/LEN and GO
//   st_busy, st_armed      : status bits for CTRL readback
//   done_set               : engine entering DONE
//   eng_upd, eng_*         : engine post-write update of the working copies
//   src, dst, len          : current working copies
//   go, go_vbl, abort      : CTRL write strobes
// ---------------------------------------------------------------------------
module vblank_dma_regs
  import dma_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFFF8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_we,
  output logic        reg_hit,
  output logic [15:0] reg_rdata,
  input  logic        lock,
  input  logic        st_busy,
  input  logic        st_armed,
  input  logic        done_set,
  input  logic        eng_upd,
  input  logic [15:0] eng_src,
  input  logic [14:0] eng_dst,
  input  logic [15:0] eng_len,
  output logic [15:0] src,
  output logic [14:0] dst,
  output logic [15:0] len,
  output logic        go,
  output logic        go_vbl,
  output logic        abort
);

  logic [15:0] src_q, src_d;
  logic [14:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic        done_q, done_d;

  logic [15:0] off;
  logic [1:0]  sel;
  logic        wr_en;
  logic        ctrl_wr;

  // Subtracting the base keeps the decode correct for any BASE_ADDR,
  // including windows that straddle a 4-word boundary.
  assign off     = cpu_addr - BASE_ADDR;
  assign sel     = off[1:0];
  assign reg_hit = (off[15:2] == 14'd0);
  assign wr_en   = cpu_we && reg_hit;
  assign ctrl_wr = wr_en && (sel == OFF_CTRL);

  assign go     = ctrl_wr && cpu_wdata[CTRL_GO] && !lock;
  assign go_vbl = cpu_wdata[CTRL_VBL];
  assign abort  = ctrl_wr && cpu_wdata[CTRL_ABORT];

  assign src = src_q;
  assign dst = dst_q;
  assign len = len_q;

  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    len_d  = len_q;
    done_d = done_q;

    // The CPU is held while the engine updates, so the two never coincide.
    if (eng_upd) begin
      src_d = eng_src;
      dst_d = eng_dst;
      len_d = eng_len;
    end else if (wr_en && !lock) begin
      case (sel)
        OFF_SRC: src_d = cpu_wdata;
        OFF_DST: dst_d = cpu_wdata[14:0];
        OFF_LEN: len_d = cpu_wdata;
        default: ;
      endcase
    end

    if (done_set)
      done_d = 1'b1;
    else if (ctrl_wr)
      done_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      len_q  <= len_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    reg_rdata = '0;
    if (reg_hit) begin
      case (sel)
        OFF_SRC: reg_rdata = src_q;
        OFF_DST: reg_rdata = {1'b0, dst_q};
        OFF_LEN: reg_rdata = len_q;
        default: begin
          reg_rdata[STAT_BUSY]  = st_busy;
          reg_rdata[STAT_DONE]  = done_q;
          reg_rdata[STAT_ARMED] = st_armed;
        end
      endcase
    end
  end

endmodule

// File: rtl/vblank_dma.sv
// ---------------------------------------------------------------------------
// vblank_dma
// DMA engine on the CPU16 bus: copies LEN words from any CPU-visible address
// into the 15-bit RAM space, holding the CPU while it runs; optionally waits
// for the next vblank rising edge before starting.
//   clk      : system clock
//   reset    : async active-low reset
//   vblank   : level, high during vertical blank
//   dma_busy : CPU hold / address-mux select
//   irq_done : one-cycle pulse on completion or abort
//   bus      : CPU register port and DMA bus port (vblank_dma_if.slave)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for GO
// ARMED    | GO with VBL seen, waiting for a registered vblank rise
// READ     | source address on the bus, waiting for grant
// WAIT     | read data returning; replay READ if the bus was stolen
// WRITE    | destination write, held until granted
// DONE     | one cycle: done status set, irq_done pulsed
// ---------------------------------------------------------------------------
module vblank_dma
  import dma_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFFF8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         vblank,
  output logic         dma_busy,
  output logic         irq_done,
  vblank_dma_if.slave  bus
);

  dma_state_e  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        irq_q, irq_d;
  logic        abort_pend_q, abort_pend_d;
  logic        vbl_s1_q, vbl_s2_q;

  logic [15:0] src, len;
  logic [14:0] dst;
  logic        go, go_vbl, abort;
  logic        eng_upd;
  logic        vbl_rise;

  assign vbl_rise = vbl_s1_q && !vbl_s2_q;

  vblank_dma_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (bus.cpu_addr),
    .cpu_wdata (bus.cpu_wdata),
    .cpu_we    (bus.cpu_we),
    .reg_hit   (bus.reg_hit),
    .reg_rdata (bus.reg_rdata),
    .lock      (busy_q || (state_q == ST_ARMED)),
    .st_busy   (busy_q),
    .st_armed  (state_q == ST_ARMED),
    .done_set  (irq_d),
    .eng_upd   (eng_upd),
    .eng_src   (src + 16'd1),
    .eng_dst   (dst + 15'd1),
    .eng_len   (len - 16'd1),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .go        (go),
    .go_vbl    (go_vbl),
    .abort     (abort)
  );

  always_comb begin
    state_d      = state_q;
    abort_pend_d = abort_pend_q;
    wdata_d      = wdata_q;
    eng_upd      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go) state_d = start_state(go_vbl, len);
      end
      ST_DONE: begin
        state_d = go ? start_state(go_vbl, len) : ST_IDLE;
      end
      ST_ARMED: begin
        if (abort)         state_d = ST_DONE;
        else if (vbl_rise) state_d = start_state(1'b0, len);
      end
      ST_READ: begin
        if (abort)              state_d = ST_DONE;
        else if (bus.dma_grant) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_DONE;
        end else if (!bus.dma_grant) begin
          state_d = ST_READ;
        end else begin
          wdata_d = bus.dma_rdata;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // An abort here lets the pending write land before stopping.
        if (bus.dma_grant) begin
          eng_upd      = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = (abort || abort_pend_q || len == 16'd1) ? ST_DONE : ST_READ;
        end else if (abort) begin
          abort_pend_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = is_busy(state_d);
    we_d   = (state_d == ST_WRITE);
    irq_d  = (state_d == ST_DONE);

    case (state_d)
      ST_READ:  addr_d = eng_upd ? (src + 16'd1) : src;
      ST_WRITE: addr_d = {1'b0, eng_upd ? (dst + 15'd1) : dst};
      default:  addr_d = '0;
    endcase

    if (!busy_d) wdata_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      irq_q        <= 1'b0;
      abort_pend_q <= 1'b0;
      vbl_s1_q     <= 1'b0;
      vbl_s2_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      irq_q        <= irq_d;
      abort_pend_q <= abort_pend_d;
      vbl_s1_q     <= vblank;
      vbl_s2_q     <= vbl_s1_q;
    end
  end

  // The write strobe follows grant within the WRITE cycle so a stolen bus
  // cycle simply delays the write.
  assign bus.dma_we    = we_q && bus.dma_grant;
  assign bus.dma_addr  = addr_q;
  assign bus.dma_wdata = wdata_q;
  assign dma_busy      = busy_q;
  assign irq_done      = irq_q;

endmodule

// File: tb/tb_vblank_dma.sv
module tb_vblank_dma;

  localparam logic [15:0] A_SRC  = 16'hFFF8;
  localparam logic [15:0] A_DST  = 16'hFFF9;
  localparam logic [15:0] A_LEN  = 16'hFFFA;
  localparam logic [15:0] A_CTRL = 16'hFFFB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vblank = 1'b0;
  logic dma_busy, irq_done;
  logic [15:0] rd_q = '0;

  vblank_dma_if bus();

  vblank_dma #(.BASE_ADDR(16'hFFF8)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .vblank   (vblank),
    .dma_busy (dma_busy),
    .irq_done (irq_done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1357;
  endfunction

  // Bus model: data for the address seen at an edge is valid next cycle,
  // but only if the bus is granted then; otherwise it is garbage.
  always @(posedge clk) rd_q <= pat(bus.dma_addr);
  assign bus.dma_rdata = bus.dma_grant ? rd_q : 16'hDEAD;

  logic [15:0] wr_a[$];
  logic [15:0] wr_d[$];
  int busy_cnt = 0;
  int irq_cnt  = 0;

  always @(posedge clk) begin
    if (bus.dma_we) begin
      wr_a.push_back(bus.dma_addr);
      wr_d.push_back(bus.dma_wdata);
    end
    if (dma_busy) busy_cnt <= busy_cnt + 1;
    if (irq_done) irq_cnt  <= irq_cnt + 1;
  end

  int n_chk = 0;
  int n_err = 0;
  int bc0, ic0, wb;
  logic [15:0] d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [15:0] v);
    @(negedge clk);
    bus.cpu_addr  = a;
    bus.cpu_wdata = v;
    bus.cpu_we    = 1'b1;
    @(negedge clk);
    bus.cpu_we    = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [15:0] v);
    @(negedge clk);
    bus.cpu_addr = a;
    #1;
    v = bus.reg_rdata;
  endtask

  task automatic mark();
    bc0 = busy_cnt;
    ic0 = irq_cnt;
    wb  = wr_a.size();
  endtask

  task automatic wait_irq(input int budget);
    int n;
    n = 0;
    while (irq_cnt == ic0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (irq_cnt == ic0) chk("irq_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_copy(input string tag, input int n, input logic [15:0] s0,
                          input logic [14:0] d0);
    logic [15:0] sa;
    logic [14:0] da;
    chk({tag, "_nwr"}, wr_a.size() - wb, n);
    for (int i = 0; i < n; i++) begin
      if (wb + i < wr_a.size()) begin
        sa = s0 + 16'(i);
        da = d0 + 15'(i);
        chk({tag, "_addr"}, wr_a[wb + i], {1'b0, da});
        chk({tag, "_data"}, wr_d[wb + i], pat(sa));
      end
    end
  endtask

  task automatic setup(input logic [15:0] s, input logic [15:0] dd, input logic [15:0] l);
    cpu_wr(A_SRC, s);
    cpu_wr(A_DST, dd);
    cpu_wr(A_LEN, l);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit [0:5] gpat;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_we    = 1'b0;
    bus.dma_grant = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy_in", dma_busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state and decode boundaries
    chk("rst_busy", dma_busy, 0);
    chk("rst_we", bus.dma_we, 0);
    chk("rst_addr", bus.dma_addr, 0);
    chk("rst_wdata", bus.dma_wdata, 0);
    chk("rst_irq", irq_done, 0);
    for (int i = 0; i < 4; i++) begin
      cpu_rd(A_SRC + 16'(i), d);
      chk("rst_reg", d, 0);
      chk("hit_in", bus.reg_hit, 1);
    end
    cpu_rd(16'hFFF7, d);
    chk("hit_below", bus.reg_hit, 0);
    cpu_rd(16'hFFFC, d);
    chk("hit_above", bus.reg_hit, 0);

    // Case 1: plain 4-word copy from ROM
    setup(16'h8000, 16'h7F00, 16'd4);
    mark();
    cpu_wr(A_CTRL, 16'h0001);
    wait_irq(60);
    chk_copy("c1", 4, 16'h8000, 15'h7F00);
    chk("c1_busy", busy_cnt - bc0, 12);
    chk("c1_irq", irq_cnt - ic0, 1);
    cpu_rd(A_CTRL, d); chk("c1_ctrl", d, 16'h0002);
    cpu_rd(A_SRC, d);  chk("c1_src", d, 16'h8004);
    cpu_rd(A_DST, d);  chk("c1_dst", d, 16'h7F04);
    cpu_rd(A_LEN, d);  chk("c1_len", d, 16'h0000);

    // Case 2: armed start on vblank rise only
    vblank = 1'b1;
    setup(16'h8000, 16'h7F10, 16'd2);
    mark();
    cpu_wr(A_CTRL, 16'h0003);
    repeat (4) @(negedge clk);
    chk("c2_nostart_hi", dma_busy, 0);
    cpu_rd(A_CTRL, d); chk("c2_armed", d, 16'h0004);
    cpu_wr(A_LEN, 16'd9);
    cpu_rd(A_LEN, d);  chk("c2_len_locked", d, 16'd2);
    vblank = 1'b0;
    repeat (3) @(negedge clk);
    chk("c2_nostart_lo", dma_busy, 0);
    vblank = 1'b1;
    @(negedge clk);
    chk("c2_start_1", dma_busy, 0);
    @(negedge clk);
    chk("c2_start_2", dma_busy, 1);
    cpu_rd(A_CTRL, d); chk("c2_ctrl_run", d, 16'h0001);
    wait_irq(60);
    chk_copy("c2", 2, 16'h8000, 15'h7F10);
    chk("c2_busy", busy_cnt - bc0, 6);

    // Case 3: grant stolen in WAIT (replay) and in WRITE (delay)
    setup(16'h8000, 16'h7F00, 16'd4);
    mark();
    gpat = 6'b101101;
    cpu_wr(A_CTRL, 16'h0001);
    bus.dma_grant = gpat[0];
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      bus.dma_grant = gpat[k];
    end
    @(negedge clk);
    bus.dma_grant = 1'b1;
    wait_irq(80);
    chk_copy("c3", 4, 16'h8000, 15'h7F00);
    chk("c3_busy", busy_cnt - bc0, 15);

    // Case 4: source and destination wrap
    setup(16'hFFFF, 16'h7FFE, 16'd3);
    mark();
    cpu_wr(A_CTRL, 16'h0001);
    wait_irq(60);
    chk_copy("c4", 3, 16'hFFFF, 15'h7FFE);
    cpu_rd(A_SRC, d); chk("c4_src", d, 16'h0002);
    cpu_rd(A_DST, d); chk("c4_dst", d, 16'h0001);

    // Case 5a: zero length
    mark();
    cpu_wr(A_CTRL, 16'h0001);
    chk("c5_irq_next", irq_done, 1);
    repeat (3) @(negedge clk);
    chk("c5_nwr", wr_a.size() - wb, 0);
    chk("c5_busy", busy_cnt - bc0, 0);
    chk("c5_irq", irq_cnt - ic0, 1);

    // Case 5b: abort during a stalled WRITE of the second word
    setup(16'h8000, 16'h7F20, 16'd8);
    mark();
    cpu_wr(A_CTRL, 16'h0001);
    repeat (4) @(negedge clk);
    @(negedge clk);
    bus.dma_grant = 1'b0;
    bus.cpu_addr  = A_CTRL;
    bus.cpu_wdata = 16'h0004;
    bus.cpu_we    = 1'b1;
    @(negedge clk);
    bus.cpu_we    = 1'b0;
    bus.dma_grant = 1'b1;
    wait_irq(60);
    chk_copy("c5b", 2, 16'h8000, 15'h7F20);
    chk("c5b_busy", busy_cnt - bc0, 7);
    cpu_rd(A_LEN, d);  chk("c5b_len", d, 16'd6);
    cpu_rd(A_SRC, d);  chk("c5b_src", d, 16'h8002);
    cpu_rd(A_DST, d);  chk("c5b_dst", d, 16'h7F22);
    cpu_rd(A_CTRL, d); chk("c5b_ctrl", d, 16'h0002);

    // Case 5c: abort while armed (vblank already high, never rises)
    cpu_wr(A_LEN, 16'd2);
    cpu_wr(A_CTRL, 16'h0003);
    repeat (3) @(negedge clk);
    cpu_rd(A_CTRL, d); chk("c5c_armed", d, 16'h0004);
    mark();
    cpu_wr(A_CTRL, 16'h0004);
    wait_irq(20);
    chk("c5c_nwr", wr_a.size() - wb, 0);
    cpu_rd(A_CTRL, d); chk("c5c_ctrl", d, 16'h0002);
    cpu_rd(A_LEN, d);  chk("c5c_len", d, 16'd2);

    // Case 6: reset during WRITE
    setup(16'h8000, 16'h7F40, 16'd4);
    mark();
    cpu_wr(A_CTRL, 16'h0001);
    repeat (2) @(negedge clk);
    chk("c6_we_pre", bus.dma_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("c6_busy", dma_busy, 0);
    chk("c6_we", bus.dma_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_rd(A_SRC + 16'(i), d);
      chk("c6_reg", d, 0);
    end
    chk("c6_nwr", wr_a.size() - wb, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
